// File: rtl/aes_pkg.sv
// Shared AES datapath constants and byte-addressing helper.
// A state is column-major: byte(r,c) is byte number 4c+r, and byte 0 occupies
// the most significant byte of a 128-bit vector, so a state reads in hex in
// byte order.
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int COL_W   = 32;
  localparam int STATE_W = 128;
  localparam int NB      = 4;

  // Two overlapping phases: collection always runs, HOLD marks a pending block
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } pk_state_e;

  // Byte index of row r, column c within a state
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_row128.sv
// Pure combinational forward ShiftRows on a 128-bit state.
// Row r of the result is row r of the input rotated left by r bytes.
module shift_row128
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] state_i,
  output logic [STATE_W-1:0] state_o
);

  // Each output byte (r,c) takes input byte (r,(c+r) mod 4)
  always_comb begin
    state_o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        state_o[STATE_W-1-BYTE_W*byte_idx(r, c) -: BYTE_W] =
          state_i[STATE_W-1-BYTE_W*byte_idx(r, (c + r) % NB) -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/shift_rows_col_packer.sv
// Column-serial forward ShiftRows stage for the AES encrypt datapath.
// Collects four 32-bit columns, permutes the completed state and holds the
// result in an output register behind a valid/ready handshake. Collection of
// the next block continues while the previous one waits to drain; only the
// completing column waits for the output register to free up.
module shift_rows_col_packer
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COL_W-1:0]    in_col,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [STATE_W-1:0]  out_state
);

  logic [1:0]             col_cnt_q, col_cnt_d;
  pk_state_e              state_q, state_d;
  logic [3*COL_W-1:0]     buf_q, buf_d;
  logic [STATE_W-1:0]     out_state_q, out_state_d;
  logic [STATE_W-1:0]     shifted;
  logic                   accept;
  logic                   complete;
  logic                   drain;

  assign out_valid = (state_q == ST_HOLD);
  assign out_state = out_state_q;

  // Only the completing beat depends on the output register being free
  assign in_ready = (col_cnt_q != 2'd3) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (col_cnt_q == 2'd3);
  assign drain    = out_valid && out_ready;

  // Column 0 lands in the most significant slot, the live column is last
  shift_row128 u_shift (
    .state_i ({buf_q, in_col}),
    .state_o (shifted)
  );

  // Next-state: flush wins, otherwise store a column or load the finished block
  always_comb begin
    col_cnt_d   = col_cnt_q;
    state_d     = state_q;
    buf_d       = buf_q;
    out_state_d = out_state_q;
    if (clr) begin
      col_cnt_d = 2'd0;
      state_d   = ST_COLLECT;
    end else begin
      if (accept) begin
        col_cnt_d = col_cnt_q + 2'd1;
        case (col_cnt_q)
          2'd0:    buf_d[3*COL_W-1 -: COL_W] = in_col;
          2'd1:    buf_d[2*COL_W-1 -: COL_W] = in_col;
          2'd2:    buf_d[COL_W-1   -: COL_W] = in_col;
          default: out_state_d               = shifted;
        endcase
      end
      // A completing beat in the same cycle as a drain keeps the block valid
      if (complete) begin
        state_d = ST_HOLD;
      end else if (drain) begin
        state_d = ST_COLLECT;
      end
    end
  end

  // Control registers: column counter and hold state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= 2'd0;
      state_q   <= ST_COLLECT;
    end else begin
      col_cnt_q <= col_cnt_d;
      state_q   <= state_d;
    end
  end

  // Data registers: assembly buffer and output block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      out_state_q <= '0;
    end else begin
      buf_q       <= buf_d;
      out_state_q <= out_state_d;
    end
  end

endmodule

// File: tb/tb_shift_rows_col_packer.sv
// Self-checking bench for shift_rows_col_packer: directed scenarios plus
// random streaming against a queue-based reference model.
module tb_shift_rows_col_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_col;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int checks = 0;
  int errors = 0;
  int drained = 0;
  bit rand_ready = 1'b0;

  logic [31:0]  cols[$];
  logic [127:0] expq[$];
  logic [127:0] origq[$];

  always #5 clk = ~clk;

  shift_rows_col_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: split into rows, rotate each row left by its index
  function automatic logic [127:0] fwd_shift(input logic [127:0] s);
    logic [7:0] row [4];
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[c] = s[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = row[(c + r) % 4];
    end
    return o;
  endfunction

  // Inverse ShiftRows: rotate each row right by its index
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [7:0] row [4];
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[c] = s[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = row[(c + 4 - r) % 4];
    end
    return o;
  endfunction

  // Reference model: sampled mid-cycle, describes what the next edge does
  always @(negedge clk) begin
    if (!rst_n) begin
      cols.delete();
      expq.delete();
      origq.delete();
    end else begin
      check("out_valid", {127'd0, out_valid}, {127'd0, expq.size() > 0});
      check("in_ready", {127'd0, in_ready},
            {127'd0, (cols.size() != 3) || (expq.size() == 0) || out_ready});
      if (expq.size() > 0) check("out_state", out_state, expq[0]);
      if (clr) begin
        cols.delete();
        expq.delete();
        origq.delete();
      end else begin
        if (out_valid && out_ready && expq.size() > 0) begin
          check("roundtrip", inv_shift(out_state), origq[0]);
          void'(expq.pop_front());
          void'(origq.pop_front());
          drained++;
        end
        if (in_valid && in_ready) begin
          cols.push_back(in_col);
          if (cols.size() == 4) begin
            origq.push_back({cols[0], cols[1], cols[2], cols[3]});
            expq.push_back(fwd_shift({cols[0], cols[1], cols[2], cols[3]}));
            cols.delete();
          end
        end
      end
    end
  end

  // Random back-pressure when enabled
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_col(input logic [31:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_col   = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("send_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", {127'd0, n < 100}, 128'd1);
  endtask

  logic [31:0]  basic_cols [4];
  logic [127:0] blk;
  int           start;

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_col    = '0;
    out_ready = 1'b0;
    basic_cols[0] = 32'h00010203;
    basic_cols[1] = 32'h04050607;
    basic_cols[2] = 32'h08090a0b;
    basic_cols[3] = 32'h0c0d0e0f;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_out_state", out_state, 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic permutation, back-to-back columns
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_col   = basic_cols[i];
      @(posedge clk);
      #1;
      if (i == 2) check("basic_early", {127'd0, out_valid}, 128'd0);
    end
    in_valid = 1'b0;
    check("basic_valid", {127'd0, out_valid}, 128'd1);
    check("basic_state", out_state, 128'h00050a0f_04090e03_080d0207_0c01060b);
    @(posedge clk);
    #1;
    check("basic_pulse", {127'd0, out_valid}, 128'd0);

    // Back-pressure: one block pending, next block stalls on its last column
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_col($urandom);
    blk = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_col   = blk[127-32*i -: 32];
      @(negedge clk);
      check("bp_accept", {127'd0, in_ready}, 128'd1);
      @(posedge clk);
      #1;
    end
    in_col = blk[31:0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall", {127'd0, in_ready}, 128'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_valid", {127'd0, out_valid}, 128'd1);
    check("bp_state", out_state, fwd_shift(blk));
    wait_drain();

    // Flush after two columns, with a column presented during clr
    send_col($urandom);
    send_col($urandom);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_col   = $urandom;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("flush_cnt", {126'd0, dut.col_cnt_q}, 128'd0);
    check("flush_valid", {127'd0, out_valid}, 128'd0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) send_col(blk[127-32*i -: 32]);
    check("flush_state", out_state, fwd_shift(blk));
    wait_drain();

    // Async reset mid-block while a block is pending
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_col($urandom);
    send_col($urandom);
    send_col($urandom);
    check("ar_pending", {127'd0, out_valid}, 128'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {127'd0, out_valid}, 128'd0);
    check("ar_state", out_state, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ar_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    blk = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) send_col(blk[127-32*i -: 32]);
    check("ar_state_after", out_state, fwd_shift(blk));
    wait_drain();

    // Streaming: random gaps and random back-pressure
    start = drained;
    rand_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_col($urandom);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
    check("stream_count", 128'(drained - start), 128'd8);

    // Round-trip through inverse ShiftRows on 16 random states
    start = drained;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 4; i++) send_col($urandom);
    end
    wait_drain();
    check("rt_count", 128'(drained - start), 128'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_rows_col_packer.md
# shift_rows_col_packer

Column-serial forward ShiftRows stage for the AES encryption datapath, the encrypt-side counterpart of the inverse-ShiftRows logic used on the decrypt path. It accepts a 128-bit state as four 32-bit columns over a valid/ready stream and applies the forward ShiftRows permutation. It presents the result as a registered 128-bit block on a second valid/ready stream. It sits between the column-wide SubBytes output and the MixColumns/AddRoundKey input of the iterative cipher.

## Interface
- None: no parameters.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; discards any partial block and the output block
- in_valid  in  1  in_col holds a valid column
- in_ready  out  1  block accepts a column this cycle
- in_col  in  [0:31]  one state column; row 0 in bits 0:7, row 3 in bits 24:31
- out_valid  out  1  out_state holds a valid block
- out_ready  in  1  downstream accepts out_state this cycle
- out_state  out  [0:127]  shifted state; byte i = row (i mod 4), column (i div 4), at bits 8i:8i+7

## Operation
- Byte addressing is column-major: byte(r,c) sits at bits 8(4c+r) to 8(4c+r)+7.
- Forward ShiftRows rule: out byte(r,c) = in byte(r,(c+r) mod 4).
  - Row 0 is unshifted.
  - Rows 1, 2 and 3 rotate left by 1, 2 and 3 bytes.
- Columns arrive in order c = 0, 1, 2, 3. A 2-bit column counter col_cnt sets the write slot in a 96-bit assembly buffer (columns 0 to 2).
- An accept happens when in_valid and in_ready are both high.
  - For col_cnt < 3: store the column, then col_cnt++.
  - For col_cnt = 3 (completing beat): the buffer plus in_col pass through the permutation and load out_state; out_valid sets; col_cnt wraps to 0.
- in_ready = (col_cnt != 3) || !out_valid || out_ready.
  - Columns 0 to 2 are always accepted while the output is stalled.
  - Only the completing beat waits for the output register to be free.
- Output drains when out_valid and out_ready are both high.
  - out_valid clears unless a completing beat is accepted in the same cycle; in that case the new block loads and out_valid stays 1.
- out_state holds stable while out_valid = 1 and out_ready = 0.
- clr (synchronous, highest priority after reset): col_cnt goes to 0 and out_valid goes to 0. Any column presented in the same cycle is dropped.
- FSM: two states, derived from col_cnt and out_valid.
  - IDLE/COLLECT is col_cnt 0 to 3.
  - HOLD is out_valid = 1.
  - The states overlap: collection of the next block proceeds during HOLD.

## Timing
- Reset values: out_valid = 0, out_state = 0, col_cnt = 0, assembly buffer = 0.
- in_ready is therefore 1 out of reset, because col_cnt = 0.
- in_ready is combinational from col_cnt, out_valid and out_ready. No path from in_valid to in_ready.
- Latency: completing beat accepted at edge N, then out_valid = 1 after edge N (one cycle).
- Throughput: one block per 4 cycles with no bubbles when out_ready is held high.
- Simultaneous drain and completing beat: handled in one cycle with no bubble.
- Reset asserted mid-block: all state clears immediately (asynchronously). The partial block is lost; no output is produced.
- clr asserted mid-block: same effect as reset, but at the next edge.

## Structure
- Shared package aes_pkg holds:
  - BYTE_W = 8, COL_W = 32, STATE_W = 128
  - NB = 4 (number of columns)
  - byte-index helper: byte(r,c) = 4c+r
- One combinational sub-module: shift_row128. It is a pure forward-ShiftRows permutation of a 128-bit state, using the same bit ordering as out_state. It is instantiated once on the completing-beat path.
- Sequential logic (counter, buffer, output register, handshake) stays in the top module.

## Test plan
- Basic permutation:
  - Stimulus: after reset, stream columns 00010203, 04050607, 08090a0b, 0c0d0e0f back-to-back with out_ready = 1.
  - Required response: out_state = 00050a0f_04090e03_080d0207_0c01060b, with out_valid pulsing exactly 1 cycle after the 4th accept.
- Back-pressure:
  - Stimulus: hold out_ready = 0 with one block pending, then send 4 more columns.
  - Required response: columns 0 to 2 accepted; in_ready = 0 on column 3; out_state stable.
  - Stimulus: release out_ready.
  - Required response: the old block drains and the new block loads in the same cycle.
- Streaming:
  - Stimulus: 8 random blocks with in_valid and out_ready randomly toggled.
  - Required response: every output equals the reference model result byte(r,c) = in(r,(c+r) mod 4); no loss and no duplication.
- Flush:
  - Stimulus: after 2 columns, assert clr for one cycle, then send a full new block.
  - Required response: output equals the new block only; col_cnt is back at 0 after clr.
- Async reset mid-block:
  - Stimulus: drop rst_n between clock edges after column 1 while out_valid = 1.
  - Required response: out_valid = 0 and out_state = 0 immediately; in_ready = 1 after release.
- Round-trip:
  - Stimulus: feed the output through the existing inverse-ShiftRows module.
  - Required response: result equals the original input for 16 random states.
